// File: rtl/alu_arbiter_if.sv
// Request/response, shared-ALU and status signals of the two-requester ALU arbiter.
interface alu_arbiter_if;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op,    req1_op;
  logic [31:0] req0_a,     req0_b;
  logic [31:0] req1_a,     req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_r,     rsp1_r;
  logic        rsp0_z,     rsp1_z;
  logic [31:0] alu_a,      alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_r;
  logic        alu_z;
  logic        busy;

  // Environment side: requesters and the shared ALU.
  modport master (
    output req0_valid, req1_valid, req0_op, req1_op,
           req0_a, req0_b, req1_a, req1_b, alu_r, alu_z,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp0_r, rsp1_r, rsp0_z, rsp1_z, alu_a, alu_b, alu_op, busy
  );

  // Arbiter side.
  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op,
           req0_a, req0_b, req1_a, req1_b, alu_r, alu_z,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp0_r, rsp1_r, rsp0_z, rsp1_z, alu_a, alu_b, alu_op, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters;
// multiply holds the operands for MUL_LAT cycles, everything else for one.
module alu_arbiter #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DW    = 32;
  localparam logic [2:0]  OP_MUL = 3'b100;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [2:0]       op_q,    op_d;
  logic [DW-1:0]    a_q,     a_d;
  logic [DW-1:0]    b_q,     b_d;
  logic             id_q,    id_d;
  logic             last_q,  last_d;
  logic [DW-1:0]    r_q,     r_d;
  logic             z_q,     z_d;

  logic             grant_c;
  logic             ready0_c, ready1_c;
  logic [2:0]       sel_op_c;

  // Tie goes to whoever was not served last; a lone requester always wins.
  always_comb begin
    grant_c = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant_c = ~last_q;
    else if (bus.req1_valid)              grant_c = 1'b1;
  end

  assign ready0_c = rst_n && (state_q == IDLE) && bus.req0_valid && !grant_c;
  assign ready1_c = rst_n && (state_q == IDLE) && bus.req1_valid &&  grant_c;
  assign sel_op_c = grant_c ? bus.req1_op : bus.req0_op;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    id_d    = id_q;
    last_d  = last_q;
    r_d     = r_q;
    z_d     = z_q;
    unique case (state_q)
      IDLE: begin
        if (ready0_c || ready1_c) begin
          state_d = EXEC;
          op_d    = sel_op_c;
          a_d     = grant_c ? bus.req1_a : bus.req0_a;
          b_d     = grant_c ? bus.req1_b : bus.req0_b;
          id_d    = grant_c;
          last_d  = grant_c;
          cnt_d   = (sel_op_c == OP_MUL) ? CNT_W'(MUL_LAT - 1) : '0;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          r_d     = bus.alu_r;
          z_d     = bus.alu_z;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
      r_q     <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      id_q    <= id_d;
      last_q  <= last_d;
      r_q     <= r_d;
      z_q     <= z_d;
    end
  end

  // Outputs decode directly from registered state so reset clears them at once.
  assign bus.req0_ready = ready0_c;
  assign bus.req1_ready = ready1_c;
  assign bus.alu_op     = (state_q == EXEC) ? op_q : 3'b000;
  assign bus.alu_a      = (state_q == EXEC) ? a_q  : '0;
  assign bus.alu_b      = (state_q == EXEC) ? b_q  : '0;
  assign bus.rsp0_valid = (state_q == DONE) && !id_q;
  assign bus.rsp1_valid = (state_q == DONE) &&  id_q;
  assign bus.rsp0_r     = r_q;
  assign bus.rsp1_r     = r_q;
  assign bus.rsp0_z     = z_q;
  assign bus.rsp1_z     = z_q;
  assign bus.busy       = (state_q != IDLE);
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: MUL_LAT, default 3, cycles the ALU operands are held for opcode 3'b100 (multiply); legal range 1..15.
REQ-002 Clocking: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid, req1_valid  input  1 each  requester N has an operation pending.
REQ-006 req0_ready, req1_ready  output  1 each  arbiter accepts requester N this cycle.
REQ-007 req0_op, req1_op  input  3 each  ALU opcode: 001 add, 010 and, 011 or, 100 mul, 101 sub, 110 set-less-than.
REQ-008 req0_a, req0_b, req1_a, req1_b  input  32 each  operands.
REQ-009 rsp0_valid, rsp1_valid  output  1 each  one-cycle result pulse to requester N.
REQ-010 rsp0_r, rsp1_r  output  32 each  result; rsp0_z, rsp1_z  output  1 each  zero flag.
REQ-011 alu_a, alu_b  output  32 each; alu_op  output  3: drive to the shared combinational ALU.
REQ-012 alu_r  input  32; alu_z  input  1: ALU result and zero flag.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM states: IDLE, EXEC, DONE; transitions IDLE->EXEC on accept, EXEC->DONE when the hold counter expires, DONE->IDLE unconditionally.
REQ-015 reqN_ready is combinational: high only in IDLE, only for the granted requester, and only when reqN_valid is high; never both high.
REQ-016 Grant: only one valid -> that one; both valid -> the requester not served last; last-served pointer updates on accept only.
REQ-017 Accept (valid & ready) registers op, a, b and the requester ID in the same edge.
REQ-018 EXEC hold: 1 cycle for all opcodes except 100, which holds MUL_LAT cycles via a 4-bit down-counter.
REQ-019 In EXEC, alu_op/alu_a/alu_b equal the registered values; outside EXEC they are 3'b000, 0, 0.
REQ-020 On the last EXEC cycle, alu_r and alu_z are captured into a result register; only the captured values are presented on rspN_r/rspN_z.
REQ-021 In DONE, rspN_valid is high for exactly one cycle for the owning requester; the other rsp_valid stays low.
REQ-022 Latency: accept at edge T -> rsp_valid high in cycle T+2 (non-mul) or T+1+MUL_LAT (mul); next accept is possible at edge T+3 (non-mul).
REQ-023 No response backpressure: a requester must take the result on the pulse; rspN_r/rspN_z hold their value until the next capture.
REQ-024 Opcodes 000 and 111 are accepted and sequenced as 1-cycle ops; the captured result is whatever the ALU returns (0, Z=1 for the team ALU).
REQ-025 Requests presented while busy are ignored (ready low); requesters hold valid and operands stable until ready.

Reset
REQ-026 rst_n low forces IDLE, counter 0, last-served pointer = requester 1 (so requester 0 wins the first tie), all registers and outputs 0, ready low, busy low.
REQ-027 Reset asserted mid-operation discards the operation; no rsp_valid pulse is generated for it after release.
REQ-028 The first accept is possible on the first rising edge after rst_n deasserts.

Verification
REQ-029 Req0 add a=5, b=7 alone -> req0_ready high at T, rsp0_valid at T+2, rsp0_r=12, rsp0_z=0.
REQ-030 Req1 sub a=9, b=9 -> rsp1_r=0, rsp1_z=1; rsp0_valid stays low throughout.
REQ-031 Both valid continuously after reset (req0 and 0xF0, req1 or 0x0F) -> accepts alternate 0,1,0,1; each rsp pulse goes to the matching requester with correct results.
REQ-032 Req0 mul a=6, b=7 with MUL_LAT=3 -> alu_op=100 held 3 cycles, rsp0_valid at T+4, rsp0_r=42; req1_valid raised at T+1 is not accepted until IDLE.
REQ-033 Req0 slt a=3, b=8 then a=8, b=3 -> rsp0_r=1 then 0 (Z=0, then Z=1).
REQ-034 rst_n pulsed low during EXEC of a mul -> busy low immediately, no rsp pulse, outputs 0; next request completes normally.
